rate_converter_32to8: RTL and testbench
=======================================

RATE_CONVERTER_32TO8 -- requirements
Module: rate_converter_32to8

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width.
REQ-002 SHALL have parameter OUT_W, default 8, output byte width; IN_W/OUT_W = 4 fixed.
REQ-003 SHALL have port clk_in  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_f  input  1  divided clock from clock generator, sampled as data (word rate).
REQ-006 SHALL have port clk_4f  input  1  divided clock from clock generator, sampled as data (byte rate, 4x clk_f).
REQ-007 SHALL have port data_in  input  IN_W  word, sampled on clk_f rise event.
REQ-008 SHALL have port valid_in  input  1  qualifies data_in at clk_f rise event.
REQ-009 SHALL have port data_out  output  OUT_W  serialized byte, MSB byte first.
REQ-010 SHALL have port valid_out  output  1  data_out holds a valid byte.
REQ-011 SHALL have port overflow  output  1  sticky, word dropped.
REQ-012 SHALL have port par_out  output  1  even parity of data_out (only with RC_PARITY_EN).

Function
REQ-013 SHALL detect rf = clk_f & ~clk_f_q and r4 = clk_4f & ~clk_4f_q, where *_q are one-cycle delayed samples; no other use of clk_f/clk_4f.
REQ-014 SHALL push data_in into a 2-entry word FIFO in the cycle rf=1 and valid_in=1.
REQ-015 SHALL drop the word and set overflow when push is requested with FIFO full and no pop in the same cycle; with a same-cycle pop, the push SHALL be accepted.
REQ-016 SHALL treat a simultaneous push and pop on an empty FIFO as: pop finds nothing, push stored (pushed word not poppable until a later cycle).
REQ-017 SHALL implement FSM IDLE/SEND with byte index idx 0..3; all transitions only in cycles with r4=1.
REQ-018 IDLE, r4, FIFO non-empty: pop word into shift register, emit bits [IN_W-1:IN_W-8], valid_out=1, go SEND idx=1.
REQ-019 IDLE, r4, FIFO empty: stay IDLE, valid_out=0, data_out holds last value.
REQ-020 SEND idx 1..3, r4: emit next lower byte, idx+1; after idx=3 emitted, next r4 behaves as IDLE rule (back-to-back words without gap).
REQ-021 data_out/valid_out SHALL be registered, update on the clk_in edge ending the r4 cycle, and hold until the next r4 cycle.
REQ-022 With aligned clocks (rf and r4 coincident), first byte of a word captured at cycle t SHALL appear at t+9; sustained input at every rf SHALL stream continuously with no overflow.
REQ-023 overflow SHALL remain 1 until reset.

Reset
REQ-024 On reset: FSM IDLE, idx 0, FIFO empty, data_out 0, valid_out 0, overflow 0, par_out 0.
REQ-025 clk_f_q and clk_4f_q SHALL reset to 1 so a high clk_f/clk_4f at reset release produces no spurious rise.
REQ-026 Reset asserted mid-word SHALL discard the partial word and FIFO contents on the next edge.

Configuration
REQ-027 Macro RC_PARITY_EN defined: par_out port exists, registered with data_out, equals XOR of data_out bits.
REQ-028 RC_PARITY_EN undefined: par_out port and parity logic absent; all other behaviour identical.

Structure
REQ-029 Package rc_pkg SHALL hold IN_W/OUT_W defaults, bytes-per-word constant (4), FSM state encoding.
REQ-030 Sub-module edge_detect (rising-edge detector, reset value parameterised) SHALL be instantiated twice, for clk_f and clk_4f.

Verification
REQ-031 Reset released with clk_f=clk_4f=1 -> no rf/r4 that cycle, valid_out=0.
REQ-032 Single word 0xA1B2C3D4 at rf -> bytes A1,B2,C3,D4 on four consecutive r4 periods, first at t+9, then valid_out=0.
REQ-033 Words 0x11223344, 0x55667788 on consecutive rf -> eight bytes back-to-back, valid_out never drops, overflow=0.
REQ-034 Consumption stalled artificially (clk_4f held low) with 3 words pushed -> third dropped, overflow=1 stays until reset; after clk_4f resumes, first two words emitted intact.
REQ-035 Reset asserted after byte B2 of 0xA1B2C3D4 -> next edge valid_out=0, data_out=0; no C3/D4 emitted.
REQ-036 RC_PARITY_EN defined, byte 0x07 -> par_out=1; byte 0x03 -> par_out=0.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared constants and FSM encoding for the 32-to-8 rate converter.
package rc_pkg;
  localparam int IN_W_DEF       = 32;
  localparam int OUT_W_DEF      = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rc_state_t;
endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level sampled as data on clk_in.
// RESET_VAL sets the remembered level so a high input at reset release is not seen as a rise.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (reset) sig_q <= RESET_VAL;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/rate_converter_32to8.sv
// Word-to-byte serializer: 2-entry word FIFO filled at clk_f rises, drained MSB byte first at clk_4f rises.
// Optional even-parity output enabled by defining RC_PARITY_EN.
module rate_converter_32to8
  import rc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_f,
  input  logic             clk_4f,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic             overflow
`ifdef RC_PARITY_EN
  ,
  output logic             par_out
`endif
);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic rf, r4;
  logic push, pop;

  rc_state_t        state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [IN_W-1:0]  sr_q, sr_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             vout_q, vout_d;
  logic             ovf_q, ovf_d;
  logic [IN_W-1:0]  fifo0_q, fifo0_d;
  logic [IN_W-1:0]  fifo1_q, fifo1_d;
  logic [1:0]       cnt_q, cnt_d;

  edge_detect #(.RESET_VAL(1'b1)) u_ed_f (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_i  (clk_f),
    .rise_o (rf)
  );

  edge_detect #(.RESET_VAL(1'b1)) u_ed_4f (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_i  (clk_4f),
    .rise_o (r4)
  );

  assign push = rf & valid_in;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    vout_d  = vout_q;
    pop     = 1'b0;
    if (r4) begin
      case (state_q)
        ST_IDLE: begin
          // cnt_q is registered, so a word pushed this cycle cannot be popped yet
          if (cnt_q != 2'd0) begin
            pop     = 1'b1;
            dout_d  = fifo0_q[IN_W-1 -: OUT_W];
            sr_d    = fifo0_q << OUT_W;
            vout_d  = 1'b1;
            state_d = ST_SEND;
            idx_d   = 2'd1;
          end else begin
            vout_d  = 1'b0;
          end
        end
        ST_SEND: begin
          dout_d = sr_q[IN_W-1 -: OUT_W];
          sr_d   = sr_q << OUT_W;
          vout_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case ({push, pop})
      2'b01: begin
        fifo0_d = fifo1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          fifo0_d = data_in;
          cnt_d   = 2'd1;
        end else if (cnt_q == 2'd1) begin
          fifo1_d = data_in;
          cnt_d   = 2'd2;
        end else begin
          ovf_d   = 1'b1;
        end
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          fifo0_d = fifo1_q;
          fifo1_d = data_in;
        end else begin
          fifo0_d = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      sr_q    <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fifo0_q <= '0;
      fifo1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign overflow  = ovf_q;

`ifdef RC_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_in) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= ^dout_d;
  end

  assign par_out = par_q;
`endif
endmodule

// File: tb/tb_rate_converter_32to8.sv
// Bench for rate_converter_32to8: queue-based reference model, directed scenarios plus random traffic.
// Build with RC_PARITY_EN defined to also cover the parity output.
module tb_rate_converter_32to8;
  logic        clk_in = 1'b0;
  logic        reset, clk_f, clk_4f, valid_in;
  logic [31:0] data_in;
  logic [7:0]  data_out;
  logic        valid_out, overflow;
`ifdef RC_PARITY_EN
  logic        par_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int ph = 0;
  bit stall4 = 1'b0;
  bit hold_hi = 1'b0;

  logic [31:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  logic        m_valid = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic        m_ovf = 1'b0;
  bit          m_fp = 1'b1, m_4p = 1'b1, m_r4 = 1'b0;

  always #5 clk_in = ~clk_in;

  rate_converter_32to8 dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .clk_f     (clk_f),
    .clk_4f    (clk_4f),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow)
`ifdef RC_PARITY_EN
    ,
    .par_out   (par_out)
`endif
  );

  // One clk_in cycle: drive inputs at negedge, advance the model, return at the next negedge.
  // clk_4f period is 8 cycles, clk_f is 32 cycles, both rising at ph == 0.
  task automatic tick(input bit rst, input bit push, input logic [31:0] w);
    bit f, f4, rf, r4;
    logic [31:0] wd;
    f  = hold_hi || (ph < 16);
    f4 = hold_hi || (!stall4 && ((ph % 8) < 4));
    clk_f = f; clk_4f = f4; reset = rst; valid_in = push;
    data_in = push ? w : 32'($urandom());
    if (rst) begin
      m_fifo.delete(); m_bytes.delete();
      m_valid = 1'b0; m_data = 8'h00; m_ovf = 1'b0;
      m_fp = 1'b1; m_4p = 1'b1; m_r4 = 1'b0;
    end else begin
      rf = f && !m_fp; r4 = f4 && !m_4p;
      m_fp = f; m_4p = f4; m_r4 = r4;
      if (r4) begin
        if (m_bytes.size() == 0 && m_fifo.size() != 0) begin
          wd = m_fifo.pop_front();
          for (int k = 0; k < 4; k++) m_bytes.push_back(wd[31-8*k -: 8]);
        end
        if (m_bytes.size() != 0) begin
          m_data = m_bytes.pop_front(); m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (rf && push) begin
        if (m_fifo.size() < 2) m_fifo.push_back(w);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk_in);
    ph = (ph + 1) % 32;
  endtask

  task automatic align();
    while (ph != 0) tick(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    int seen;
    hold_hi = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid_out); end
    tests_run++;
    if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", data_out); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", overflow); end
    // release with both clocks high and a word offered: no rise may be seen
    ph = 1;
    tick(1'b0, 1'b1, 32'hDEADBEEF);
    hold_hi = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL release_valid got %b want 0", valid_out); end
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (valid_out === 1'b1) seen++;
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL release_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL release_spurious got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b[4];
    logic [7:0] got[$];
    logic [7:0] b;
    int lat;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    lat = -1;
    align();
    tick(1'b0, 1'b1, 32'hA1B2C3D4);
    for (int i = 1; i <= 48; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (valid_out === 1'b1 && lat < 0) lat = i + 1;
      if (m_r4 && valid_out === 1'b1) got.push_back(data_out);
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL single_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
    end
    tests_run++;
    if (lat !== 9) begin tests_failed++; $display("FAIL single_latency got %0d want 9", lat); end
    tests_run++;
    if (got.size() !== 4) begin tests_failed++; $display("FAIL single_count got %0d want 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      b = (k < got.size()) ? got[k] : 8'hxx;
      tests_run++;
      if (b !== exp_b[k]) begin tests_failed++; $display("FAIL single_byte%0d got %h want %h", k, b, exp_b[k]); end
    end
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL single_tail_valid got %b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[8];
    logic [7:0] got[$];
    logic [7:0] b;
    int first, last, vcnt;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    first = -1; last = -1; vcnt = 0;
    align();
    tick(1'b0, 1'b1, 32'h11223344);
    for (int i = 1; i <= 90; i++) begin
      tick(1'b0, (i == 32), 32'h55667788);
      if (valid_out === 1'b1) begin
        vcnt++; last = i;
        if (first < 0) first = i;
      end
      if (m_r4 && valid_out === 1'b1) got.push_back(data_out);
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL b2b_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
    end
    tests_run++;
    if (vcnt !== 64) begin tests_failed++; $display("FAIL b2b_valid_cycles got %0d want 64", vcnt); end
    tests_run++;
    if (last - first + 1 !== 64) begin tests_failed++; $display("FAIL b2b_gap span got %0d want 64", last - first + 1); end
    for (int k = 0; k < 8; k++) begin
      b = (k < got.size()) ? got[k] : 8'hxx;
      tests_run++;
      if (b !== exp_b[k]) begin tests_failed++; $display("FAIL b2b_byte%0d got %h want %h", k, b, exp_b[k]); end
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovf got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [31:0] w[3];
    logic [7:0] got[$];
    logic [7:0] b, e;
    for (int k = 0; k < 3; k++) w[k] = $urandom();
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    stall4 = 1'b1;
    align();
    for (int i = 0; i < 96; i++) begin
      tick(1'b0, (i % 32 == 0), w[i / 32]);
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL ovf_stall_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want 1", overflow); end
    stall4 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (m_r4 && valid_out === 1'b1) got.push_back(data_out);
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL ovf_drain_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
    end
    tests_run++;
    if (got.size() !== 8) begin tests_failed++; $display("FAIL ovf_count got %0d want 8", got.size()); end
    for (int k = 0; k < 8; k++) begin
      b = (k < got.size()) ? got[k] : 8'hxx;
      e = w[k / 4][31-8*(k%4) -: 8];
      tests_run++;
      if (b !== e) begin tests_failed++; $display("FAIL ovf_byte%0d got %h want %h", k, b, e); end
    end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    tick(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] got[$];
    int seen;
    seen = 0;
    align();
    tick(1'b0, 1'b1, 32'hA1B2C3D4);
    for (int i = 1; i <= 17; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (m_r4 && valid_out === 1'b1) got.push_back(data_out);
    end
    tests_run++;
    if (got.size() !== 2 || data_out !== 8'hB2) begin
      tests_failed++; $display("FAIL midword_pre got %0d bytes last %h want 2 bytes last b2", got.size(), data_out);
    end
    tick(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (valid_out !== 1'b0 || data_out !== 8'h00) begin
      tests_failed++; $display("FAIL midword_reset got v=%b d=%h want v=0 d=00", valid_out, data_out);
    end
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (valid_out === 1'b1) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL midword_leftover got %0d valid cycles want 0", seen); end
  endtask

`ifdef RC_PARITY_EN
  task automatic test_parity();
    int hits;
    hits = 0;
    align();
    tick(1'b0, 1'b1, 32'h0703A500);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (m_r4 && valid_out === 1'b1 && data_out === 8'h07) begin
        hits++; tests_run++;
        if (par_out !== 1'b1) begin tests_failed++; $display("FAIL parity_07 got %b want 1", par_out); end
      end
      if (m_r4 && valid_out === 1'b1 && data_out === 8'h03) begin
        hits++; tests_run++;
        if (par_out !== 1'b0) begin tests_failed++; $display("FAIL parity_03 got %b want 0", par_out); end
      end
    end
    tests_run++;
    if (hits !== 2) begin tests_failed++; $display("FAIL parity_hits got %0d want 2", hits); end
  endtask
`endif

  task automatic test_random();
    bit push;
    logic [31:0] w;
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    align();
    for (int i = 0; i < 640; i++) begin
      push = 1'b0; w = 32'h0;
      if (ph == 0) begin
        stall4 = ($urandom_range(3) == 0);
        push = ($urandom_range(3) != 0);
        w = $urandom();
      end
      tick(1'b0, push, w);
      tests_run++;
      if (valid_out !== m_valid || data_out !== m_data || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL random_cyc%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", i, valid_out, data_out, overflow, m_valid, m_data, m_ovf);
      end
`ifdef RC_PARITY_EN
      tests_run++;
      if (par_out !== ^m_data) begin
        tests_failed++; $display("FAIL random_par_cyc%0d got %b want %b", i, par_out, ^m_data);
      end
`endif
    end
    stall4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_f = 1'b1; clk_4f = 1'b1; valid_in = 1'b0; data_in = 32'h0;
    @(negedge clk_in);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midword();
`ifdef RC_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
